rgb_ycbcr_stream: RTL and testbench
===================================

RGB_YCBCR_STREAM -- requirements
Module: rgb_ycbcr_stream

Interface
REQ-001 Parameter DATA_W, default 10, SHALL set the bit width of each colour component in and out.
REQ-002 Parameter BLK, default 8, SHALL set the block edge; a block is BLK*BLK pixels in raster order.
REQ-003 clk_in  input  1  SHALL be the single clock; all state SHALL change on its rising edge only.
REQ-004 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 s_valid  input  1  SHALL mean the upstream pixel is valid.
REQ-006 s_ready  output  1  SHALL mean the block accepts a pixel this cycle.
REQ-007 r_in, g_in, b_in  input  DATA_W each  SHALL carry the unsigned R, G and B samples.
REQ-008 mode_in  input  1  SHALL select the chroma format: 0 = signed two's complement, 1 = offset binary; it is sampled per pixel with the data.
REQ-009 m_valid  output  1  SHALL mean the output pixel is valid.
REQ-010 m_ready  input  1  SHALL mean downstream accepts the output pixel.
REQ-011 y_out, cb_out, cr_out  output  DATA_W each  SHALL carry the converted pixel.
REQ-012 m_last  output  1  SHALL mark the final pixel of each block; it is qualified by m_valid.
REQ-013 pix_cnt  output  clog2(BLK*BLK)  SHALL give the index within the current block of the next pixel to be accepted.

Function
REQ-014 Transfer rules:
- An input transfer SHALL occur when s_valid and s_ready are both high.
- An output transfer SHALL occur when m_valid and m_ready are both high.
REQ-015 Pipeline: three register stages (multiply, sum, shift/offset/clamp), each with its own valid bit.
REQ-016 Advance: all stages SHALL advance together when adv = m_ready OR NOT m_valid; otherwise every stage SHALL hold.
REQ-017 s_ready SHALL equal adv; it is combinational, and s_valid SHALL NOT feed s_ready.
REQ-018 With m_ready held high, the pixel accepted in cycle N SHALL appear with m_valid in cycle N+3; throughput SHALL be one pixel per cycle.
REQ-019 While m_valid is high and m_ready is low, y_out, cb_out, cr_out, m_last and m_valid SHALL hold stable; no pixel is dropped or duplicated.
REQ-020 Coefficients SHALL be fixed Q10 constants:
- Y = 306R + 601G + 116B
- Cr = 512R - 429G - 83B
- Cb = 512B - 173R - 339G
REQ-021 Products and sums SHALL be held signed at DATA_W+12 bits; overflow SHALL NOT be possible.
REQ-022 Each sum SHALL be shifted arithmetically right by 10 bits (floor toward minus infinity).
REQ-023 Y SHALL be clamped to [0, 2^DATA_W-1].
REQ-024 In mode 0, Cb and Cr SHALL be clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and output as two's complement.
REQ-025 In mode 1, Cb and Cr SHALL have 2^(DATA_W-1) added, then be clamped to [0, 2^DATA_W-1].
REQ-026 mode_in SHALL travel through the pipeline with its pixel; changing it between pixels SHALL NOT affect pixels already accepted.
REQ-027 Block counter:
- pix_cnt SHALL increment on each input transfer.
- It SHALL wrap from BLK*BLK-1 to 0.
- A pixel accepted with pix_cnt = BLK*BLK-1 SHALL carry last = 1 through the pipeline to m_last.
REQ-028 If an input transfer and an output transfer occur in the same cycle, both SHALL take effect; pipeline occupancy is unchanged.
REQ-029 A bubble (s_valid low while adv is high) SHALL propagate as a stage with valid = 0 and SHALL NOT advance pix_cnt.

Reset
REQ-030 While reset_n is low, these SHALL be 0 asynchronously: all stage valid bits, m_valid, m_last, y_out, cb_out, cr_out and pix_cnt.
REQ-031 Reset_n deassertion SHALL be synchronised externally; reset asserted mid-block SHALL discard all in-flight pixels, and the next accepted pixel SHALL be block index 0.
REQ-032 After reset, s_ready SHALL be 1 because m_valid is 0.

Verification (DATA_W=10, BLK=8 unless noted)
REQ-033 White, mode 1: R=G=B=1023 -> Y=1022, Cb=512, Cr=512 at cycle N+3.
REQ-034 Red, mode 0: R=1023, G=B=0 -> Y=305, Cr=511, Cb=-173 (0x353). In mode 1 the same pixel gives Cr=1023, Cb=339.
REQ-035 Blue, mode 1: B=1023, R=G=0 -> Y=115, Cb=1023, Cr=429.
REQ-036 Backpressure: a continuous stream of 20 pixels with m_ready low for 5 cycles mid-stream -> all 20 outputs arrive in order with no loss or duplication, outputs stay stable while stalled, and s_ready is low while the pipeline is full.
REQ-037 Block framing: 130 pixels -> m_last on output pixels 64 and 128 only, and pix_cnt reads 2 at the end. With BLK=4, m_last SHALL be on every 16th pixel.
REQ-038 Reset mid-block: reset_n pulsed low after 37 pixels with 3 in flight -> m_valid falls immediately, no stale outputs appear, and the next block's m_last arrives after exactly 64 further pixels.

Source files
------------

// File: rtl/rgb_ycbcr_stream.sv
// rgb_ycbcr_stream: three-stage RGB to YCbCr converter with valid/ready flow control and block framing
module rgb_ycbcr_stream #(
  parameter int DATA_W = 10,
  parameter int BLK    = 8
) (
  input  logic                          clk_in,
  input  logic                          reset_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             r_in,
  input  logic [DATA_W-1:0]             g_in,
  input  logic [DATA_W-1:0]             b_in,
  input  logic                          mode_in,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_W-1:0]             y_out,
  output logic [DATA_W-1:0]             cb_out,
  output logic [DATA_W-1:0]             cr_out,
  output logic                          m_last,
  output logic [$clog2(BLK*BLK)-1:0]    pix_cnt
);
  localparam int PW   = DATA_W + 12;
  localparam int NPIX = BLK * BLK;
  localparam int CW   = $clog2(NPIX);
  typedef logic signed [PW-1:0] acc_t;
  // Product order: Y(R,G,B), Cr(R,G,B), Cb(R,G,B); Q10 fixed point
  localparam int COEF [9] = '{306, 601, 116, 512, -429, -83, -173, -339, 512};
  localparam acc_t UMAX = acc_t'((1 << DATA_W) - 1);
  localparam acc_t HALF = acc_t'(1 << (DATA_W - 1));

  logic              adv;
  acc_t              rgb [3];
  acc_t              prod_q [9], prod_d [9];
  acc_t              sum_q [3], sum_d [3];
  acc_t              sh [3];
  logic              v1_q, m1_q, l1_q, v1_d, m1_d, l1_d;
  logic              v2_q, m2_q, l2_q;
  logic              v3_q, l3_q;
  logic [DATA_W-1:0] y_q, cb_q, cr_q, y_d, cb_d, cr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Chroma shift result to either clamped two's complement or offset binary
  function automatic logic [DATA_W-1:0] chroma(input acc_t s, input logic off);
    acc_t c, lo, hi;
    c  = off ? s + HALF : s;
    lo = off ? acc_t'(0) : -HALF;
    hi = off ? UMAX : HALF - acc_t'(1);
    chroma = c < lo ? lo[DATA_W-1:0] : (c > hi ? hi[DATA_W-1:0] : c[DATA_W-1:0]);
  endfunction

  assign adv     = m_ready | ~v3_q;
  assign s_ready = adv;
  assign m_valid = v3_q;
  assign m_last  = l3_q;
  assign y_out   = y_q;
  assign cb_out  = cb_q;
  assign cr_out  = cr_q;
  assign pix_cnt = cnt_q;

  // Next-state for all three stages and the block counter
  always_comb begin
    rgb[0] = acc_t'({12'd0, r_in});
    rgb[1] = acc_t'({12'd0, g_in});
    rgb[2] = acc_t'({12'd0, b_in});
    for (int i = 0; i < 9; i++) prod_d[i] = acc_t'(COEF[i]) * rgb[i % 3];
    v1_d = s_valid;
    m1_d = mode_in;
    l1_d = s_valid && (cnt_q == CW'(NPIX - 1));
    for (int k = 0; k < 3; k++) begin
      sum_d[k] = prod_q[3*k] + prod_q[3*k+1] + prod_q[3*k+2];
      sh[k]    = sum_q[k] >>> 10;
    end
    y_d   = sh[0] < 0 ? '0 : (sh[0] > UMAX ? '1 : sh[0][DATA_W-1:0]);
    cr_d  = chroma(sh[1], m2_q);
    cb_d  = chroma(sh[2], m2_q);
    cnt_d = (s_valid && adv) ? ((cnt_q == CW'(NPIX - 1)) ? '0 : cnt_q + 1'b1) : cnt_q;
  end

  // Pipeline registers advance together on adv; counter steps on each input transfer
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      for (int k = 0; k < 3; k++) sum_q[k] <= '0;
      {v1_q, m1_q, l1_q, v2_q, m2_q, l2_q, v3_q, l3_q} <= '0;
      y_q   <= '0;
      cb_q  <= '0;
      cr_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (adv) begin
        for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
        for (int k = 0; k < 3; k++) sum_q[k] <= sum_d[k];
        v1_q <= v1_d;
        m1_q <= m1_d;
        l1_q <= l1_d;
        v2_q <= v1_q;
        m2_q <= m1_q;
        l2_q <= l1_q;
        v3_q <= v2_q;
        l3_q <= l2_q;
        y_q  <= y_d;
        cb_q <= cb_d;
        cr_q <= cr_d;
      end
    end
  end
endmodule

// File: tb/tb_rgb_ycbcr_stream.sv
// tb_rgb_ycbcr_stream: directed checks of colour conversion, flow control, framing and reset
module tb_rgb_ycbcr_stream;
  logic       clk_in = 0, reset_n = 0, s_valid = 0, mode_in = 0, m_ready = 1;
  logic [9:0] r_in = 0, g_in = 0, b_in = 0;
  logic       s_ready, m_valid, m_last, s_ready4, m_valid4, m_last4;
  logic [9:0] y_out, cb_out, cr_out, y4, cb4, cr4;
  logic [5:0] pix_cnt;
  logic [3:0] pix_cnt4;
  int compared = 0, mismatched = 0;

  rgb_ycbcr_stream #(.DATA_W(10), .BLK(8)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .mode_in(mode_in),
    .m_valid(m_valid), .m_ready(m_ready), .y_out(y_out), .cb_out(cb_out),
    .cr_out(cr_out), .m_last(m_last), .pix_cnt(pix_cnt));

  rgb_ycbcr_stream #(.DATA_W(10), .BLK(4)) dut4 (
    .clk_in(clk_in), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready4),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .mode_in(mode_in),
    .m_valid(m_valid4), .m_ready(m_ready), .y_out(y4), .cb_out(cb4),
    .cr_out(cr4), .m_last(m_last4), .pix_cnt(pix_cnt4));

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 0;
    s_valid = 0;
    m_ready = 1;
    tick;
    tick;
    reset_n = 1;
    tick;
  endtask

  task automatic test_reset;
    reset_n = 0;
    s_valid = 0;
    #3;
    compared++;
    if (m_valid !== 0 || m_last !== 0 || y_out !== 0 || cb_out !== 0 || cr_out !== 0 || pix_cnt !== 0) begin
      mismatched++;
      $display("FAIL reset_state: mv=%b last=%b y=%0d cb=%0d cr=%0d cnt=%0d, want all 0",
               m_valid, m_last, y_out, cb_out, cr_out, pix_cnt);
    end
    compared++;
    if (s_ready !== 1) begin
      mismatched++;
      $display("FAIL reset_s_ready: got %b want 1", s_ready);
    end
    tick;
    tick;
    reset_n = 1;
    tick;
    compared++;
    if (s_ready !== 1 || m_valid !== 0) begin
      mismatched++;
      $display("FAIL post_reset: s_ready=%b m_valid=%b want 1/0", s_ready, m_valid);
    end
  endtask

  task automatic test_pixel(input string name, input logic [9:0] r, input logic [9:0] g,
                            input logic [9:0] b, input logic m, input logic [9:0] ey,
                            input logic [9:0] ecb, input logic [9:0] ecr);
    r_in = r; g_in = g; b_in = b; mode_in = m;
    s_valid = 1;
    m_ready = 1;
    tick;
    s_valid = 0;
    tick;
    compared++;
    if (m_valid !== 0) begin
      mismatched++;
      $display("FAIL %s_early: m_valid=%b want 0 before N+3", name, m_valid);
    end
    tick;
    compared++;
    if (m_valid !== 1 || y_out !== ey || cb_out !== ecb || cr_out !== ecr) begin
      mismatched++;
      $display("FAIL %s: mv=%b y=%0d cb=%0d cr=%0d, want mv=1 y=%0d cb=%0d cr=%0d",
               name, m_valid, y_out, cb_out, cr_out, ey, ecb, ecr);
    end
    tick;
  endtask

  task automatic test_mode_switch;
    r_in = 1023; g_in = 0; b_in = 0;
    mode_in = 0;
    s_valid = 1;
    tick;
    mode_in = 1;
    tick;
    s_valid = 0;
    mode_in = 0;
    tick;
    compared++;
    if (m_valid !== 1 || y_out !== 305 || cb_out !== 10'h353 || cr_out !== 511) begin
      mismatched++;
      $display("FAIL mode_switch_a: mv=%b y=%0d cb=%0d cr=%0d, want 1 305 851 511",
               m_valid, y_out, cb_out, cr_out);
    end
    tick;
    compared++;
    if (m_valid !== 1 || y_out !== 305 || cb_out !== 339 || cr_out !== 1023) begin
      mismatched++;
      $display("FAIL mode_switch_b: mv=%b y=%0d cb=%0d cr=%0d, want 1 305 339 1023",
               m_valid, y_out, cb_out, cr_out);
    end
    tick;
  endtask

  task automatic test_backpressure;
    int sent = 0, got = 0, cyc = 0;
    logic stall;
    logic [9:0] hy;
    while (got < 20 && cyc < 100) begin
      m_ready = !(cyc >= 8 && cyc < 13);
      s_valid = sent < 20;
      r_in = 10'(sent + 1); g_in = 10'(sent + 1); b_in = 10'(sent + 1);
      mode_in = 1;
      #1;
      if (m_valid && m_ready) begin
        compared++;
        if (y_out !== 10'(got) || cb_out !== 512 || cr_out !== 512) begin
          mismatched++;
          $display("FAIL bp_order[%0d]: y=%0d cb=%0d cr=%0d, want y=%0d cb=512 cr=512",
                   got, y_out, cb_out, cr_out, got);
        end
        got++;
      end
      if (cyc == 10) begin
        compared++;
        if (s_ready !== 0) begin
          mismatched++;
          $display("FAIL bp_s_ready_full: got %b want 0", s_ready);
        end
      end
      stall = m_valid && !m_ready;
      hy = y_out;
      if (s_valid && s_ready) sent++;
      tick;
      if (stall) begin
        compared++;
        if (m_valid !== 1 || y_out !== hy) begin
          mismatched++;
          $display("FAIL bp_stable: mv=%b y=%0d, want mv=1 y=%0d", m_valid, y_out, hy);
        end
      end
      cyc++;
    end
    s_valid = 0;
    m_ready = 1;
    compared++;
    if (got != 20 || sent != 20) begin
      mismatched++;
      $display("FAIL bp_count: sent=%0d got=%0d want 20/20", sent, got);
    end
    tick;
  endtask

  task automatic test_framing;
    int sent = 0, got = 0, cyc = 0, lasts = 0;
    do_reset;
    while (got < 130 && cyc < 300) begin
      s_valid = sent < 130;
      r_in = 10'(sent % 1000 + 1); g_in = r_in; b_in = r_in;
      mode_in = 1;
      #1;
      if (m_valid) begin
        compared++;
        if (m_last !== (got % 64 == 63) || m_valid4 !== 1 || m_last4 !== (got % 16 == 15)) begin
          mismatched++;
          $display("FAIL frame_last[%0d]: last=%b mv4=%b last4=%b, want %b 1 %b",
                   got + 1, m_last, m_valid4, m_last4, got % 64 == 63, got % 16 == 15);
        end
        if (m_last) lasts++;
        got++;
      end
      if (s_valid && s_ready) sent++;
      tick;
      cyc++;
    end
    s_valid = 0;
    compared++;
    if (got != 130 || lasts != 2 || pix_cnt !== 2 || pix_cnt4 !== 2) begin
      mismatched++;
      $display("FAIL frame_end: got=%0d lasts=%0d cnt=%0d cnt4=%0d, want 130 2 2 2",
               got, lasts, pix_cnt, pix_cnt4);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    int sent = 0, got = 0, cyc = 0;
    logic seen = 0;
    do_reset;
    while (sent < 37 && cyc < 100) begin
      s_valid = 1;
      r_in = 10'(sent + 1); g_in = r_in; b_in = r_in;
      #1;
      if (s_ready) sent++;
      tick;
      cyc++;
    end
    s_valid = 0;
    compared++;
    if (m_valid !== 1) begin
      mismatched++;
      $display("FAIL rm_inflight: m_valid=%b want 1", m_valid);
    end
    reset_n = 0;
    #1;
    compared++;
    if (m_valid !== 0 || pix_cnt !== 0 || m_last !== 0) begin
      mismatched++;
      $display("FAIL rm_async: mv=%b cnt=%0d last=%b, want 0 0 0", m_valid, pix_cnt, m_last);
    end
    #2;
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      compared++;
      if (m_valid !== 0) begin
        mismatched++;
        $display("FAIL rm_stale[%0d]: m_valid=%b want 0", i, m_valid);
      end
    end
    sent = 0;
    cyc = 0;
    while (!seen && cyc < 200) begin
      s_valid = sent < 70;
      r_in = 10'(sent + 1); g_in = r_in; b_in = r_in;
      #1;
      if (m_valid) begin
        got++;
        if (m_last) seen = 1;
      end
      if (s_valid && s_ready) sent++;
      tick;
      cyc++;
    end
    s_valid = 0;
    compared++;
    if (!seen || got != 64) begin
      mismatched++;
      $display("FAIL rm_next_last: seen=%b at output %0d, want 1 at 64", seen, got);
    end
    tick;
    tick;
    tick;
  endtask

  initial begin
    test_reset;
    test_pixel("white_m1", 1023, 1023, 1023, 1, 1022, 512, 512);
    test_pixel("red_m0", 1023, 0, 0, 0, 305, 10'h353, 511);
    test_pixel("red_m1", 1023, 0, 0, 1, 305, 339, 1023);
    test_pixel("blue_m1", 0, 0, 1023, 1, 115, 1023, 429);
    test_pixel("blue_m0", 0, 0, 1023, 0, 115, 511, 941);
    test_pixel("green_m0", 0, 1023, 0, 0, 600, 685, 595);
    test_pixel("black_m0", 0, 0, 0, 0, 0, 0, 0);
    test_pixel("black_m1", 0, 0, 0, 1, 0, 512, 512);
    test_mode_switch;
    test_backpressure;
    test_framing;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
